// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the adder unit.
// Optional subtract support is enabled with the ADDER_SUB_EN macro.
package adder_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_PIPE_STAGES = 1;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adder_pipe_reg.sv
// One valid+data pipeline stage; data holds when the incoming valid is low.
module adder_pipe_reg
    import adder_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q, data_d;

    always_comb data_d = valid_i ? data_i : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/adder_unit.sv
// Pipelined unsigned adder; with ADDER_SUB_EN defined, sub_i selects A-B.
// Result is OUT_W = max(widths)+1 bits, PIPE_STAGES cycles after acceptance.
module adder_unit
    import adder_pkg::*;
#(
    parameter  int DATA_WIDTH_1 = DEF_DATA_WIDTH,
    parameter  int DATA_WIDTH_2 = DEF_DATA_WIDTH,
    parameter  int PIPE_STAGES  = DEF_PIPE_STAGES,
    localparam int OUT_W        = max_w(DATA_WIDTH_1, DATA_WIDTH_2) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH_1-1:0] data1_i,
    input  logic [DATA_WIDTH_2-1:0] data2_i,
`ifdef ADDER_SUB_EN
    input  logic                    sub_i,
`endif
    output logic                    valid_o,
    output logic [OUT_W-1:0]        data_o
);

    logic [OUT_W-1:0] a_ext, b_ext, res;

    assign a_ext = OUT_W'(data1_i);
    assign b_ext = OUT_W'(data2_i);

`ifdef ADDER_SUB_EN
    op_e op;
    assign op  = sub_i ? OP_SUB : OP_ADD;
    // Wraps mod 2^OUT_W, so the MSB flags A<B.
    assign res = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
`else
    assign res = a_ext + b_ext;
`endif

    logic [PIPE_STAGES:0]            vld_pipe;
    logic [PIPE_STAGES:0][OUT_W-1:0] dat_pipe;

    assign vld_pipe[0] = valid_i;
    assign dat_pipe[0] = res;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        adder_pipe_reg #(.W(OUT_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_i (vld_pipe[g]),
            .data_i  (dat_pipe[g]),
            .valid_o (vld_pipe[g+1]),
            .data_o  (dat_pipe[g+1])
        );
    end

    assign valid_o = vld_pipe[PIPE_STAGES];
    assign data_o  = dat_pipe[PIPE_STAGES];

endmodule

// File: tb/tb_adder_unit.sv
// Bench for adder_unit: one default instance and one with PIPE_STAGES=3 share stimulus.
module tb_adder_unit;

`ifdef ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [15:0] data1_i = '0;
    logic [15:0] data2_i = '0;
    logic        sub_i = 1'b0;
    logic        v1, v3;
    logic [16:0] d1, d3;

    always #5 clk = ~clk;

    adder_unit u_dut1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data1_i(data1_i), .data2_i(data2_i),
`ifdef ADDER_SUB_EN
        .sub_i(sub_i),
`endif
        .valid_o(v1), .data_o(d1)
    );

    adder_unit #(.PIPE_STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data1_i(data1_i), .data2_i(data2_i),
`ifdef ADDER_SUB_EN
        .sub_i(sub_i),
`endif
        .valid_o(v3), .data_o(d3)
    );

    typedef struct {
        int          due;
        logic [16:0] val;
    } exp_t;

    exp_t        q1[$], q3[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        ev1, ev3;
    logic [16:0] ed1, ed3, last1 = '0, last3 = '0;

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint r;
        r = (SUB_EN && s) ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
        return 17'(r & 64'h1FFFF);
    endfunction

    // Drive one edge, then work out what each instance should show just after it.
    task automatic tick(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [16:0] r;
        valid_i = v; data1_i = a; data2_i = b; sub_i = s;
        @(posedge clk);
        cyc++;
        if (v && !rst) begin
            r = model(a, b, s);
            q1.push_back('{cyc, r});
            q3.push_back('{cyc + 2, r});
        end
        #1;
        ev1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev1 = 1'b1; last1 = q1[0].val; void'(q1.pop_front());
        end
        ed1 = last1;
        ev3 = 1'b0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            ev3 = 1'b1; last3 = q3[0].val; void'(q3.pop_front());
        end
        ed3 = last3;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (v1 !== 1'b0 || d1 !== 17'h0) begin
            failures++; $display("FAIL reset_dut1 got v=%b d=%h want v=0 d=00000", v1, d1);
        end
        checks++;
        if (v3 !== 1'b0 || d3 !== 17'h0) begin
            failures++; $display("FAIL reset_dut3 got v=%b d=%h want v=0 d=00000", v3, d3);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'($urandom), 16'($urandom), 1'b0);
            checks++;
            if ({v1, d1, v3, d3} !== 36'h0) begin
                failures++; $display("FAIL reset_hold got v1=%b d1=%h v3=%b d3=%h want all 0", v1, d1, v3, d3);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_add_directed();
        logic [15:0] a[7] = '{16'h52F2, 16'h52F2, 16'h8929, 16'h8712, 16'hFFFF, 16'h0000, 16'h0000};
        logic [15:0] b[7] = '{16'h3671, 16'h2234, 16'h2234, 16'h4142, 16'hFFFF, 16'h0000, 16'h0000};
        logic [16:0] r[7] = '{17'h08963, 17'h07526, 17'h0AB5D, 17'h0C854, 17'h1FFFE, 17'h00000, 17'h00000};
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, a[i], b[i], 1'b0);
            checks++;
            if (v1 !== 1'b1 || d1 !== r[i]) begin
                failures++; $display("FAIL add_const[%0d] got v=%b d=%h want v=1 d=%h", i, v1, d1, r[i]);
            end
            checks++;
            if (v3 !== ev3 || d3 !== ed3) begin
                failures++; $display("FAIL add_dut3[%0d] got v=%b d=%h want v=%b d=%h", i, v3, d3, ev3, ed3);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'($urandom), 16'($urandom), 1'b0);
            checks++;
            if (v1 !== ev1 || d1 !== ed1 || v3 !== ev3 || d3 !== ed3) begin
                failures++;
                $display("FAIL add_drain[%0d] got v1=%b d1=%h v3=%b d3=%h want v1=%b d1=%h v3=%b d3=%h",
                         i, v1, d1, v3, d3, ev1, ed1, ev3, ed3);
            end
        end
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        tick(1'b1, 16'h52F2, 16'h3671, 1'b1);
        checks++;
        if (v1 !== 1'b1 || d1 !== 17'h01C81) begin
            failures++; $display("FAIL sub_pos got v=%b d=%h want v=1 d=01c81", v1, d1);
        end
        tick(1'b1, 16'h3671, 16'h52F2, 1'b1);
        checks++;
        if (v1 !== 1'b1 || d1 !== 17'h1E37F) begin
            failures++; $display("FAIL sub_neg got v=%b d=%h want v=1 d=1e37f", v1, d1);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b0);
            checks++;
            if (v3 !== ev3 || d3 !== ed3) begin
                failures++; $display("FAIL sub_dut3[%0d] got v=%b d=%h want v=%b d=%h", i, v3, d3, ev3, ed3);
            end
        end
    endtask
`endif

    task automatic test_pulse();
        logic       pv[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [6:0] seen;
        seen = '0;
        for (int i = 0; i < 7; i++) begin
            tick(pv[i], 16'($urandom), 16'($urandom), 1'b0);
            seen[i] = v3;
            checks++;
            if (v3 !== ev3 || d3 !== ed3) begin
                failures++; $display("FAIL pulse_dut3[%0d] got v=%b d=%h want v=%b d=%h", i, v3, d3, ev3, ed3);
            end
        end
        checks++;
        if (seen !== 7'b0010100) begin
            failures++; $display("FAIL pulse_pattern got %b want 0010100", seen);
        end
    endtask

    task automatic test_random();
        logic v, s;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = SUB_EN ? 1'($urandom) : 1'b0;
            tick(v, 16'($urandom), 16'($urandom), s);
            checks++;
            if (v1 !== ev1 || d1 !== ed1) begin
                failures++; $display("FAIL rand_dut1[%0d] got v=%b d=%h want v=%b d=%h", i, v1, d1, ev1, ed1);
            end
            checks++;
            if (v3 !== ev3 || d3 !== ed3) begin
                failures++; $display("FAIL rand_dut3[%0d] got v=%b d=%h want v=%b d=%h", i, v3, d3, ev3, ed3);
            end
        end
    endtask

    task automatic test_reset_midstream();
        tick(1'b1, 16'h1234, 16'h1111, 1'b0);
        tick(1'b1, 16'h4321, 16'h2222, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({v1, d1, v3, d3} !== 36'h0) begin
            failures++; $display("FAIL rst_async got v1=%b d1=%h v3=%b d3=%h want all 0", v1, d1, v3, d3);
        end
        q1.delete(); q3.delete();
        last1 = '0; last3 = '0;
        tick(1'b1, 16'h5555, 16'h5555, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b0);
            checks++;
            if ({v1, d1, v3, d3} !== 36'h0) begin
                failures++; $display("FAIL rst_stale[%0d] got v1=%b d1=%h v3=%b d3=%h want all 0", i, v1, d1, v3, d3);
            end
        end
        tick(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        checks++;
        if (v1 !== 1'b1 || d1 !== 17'h10000) begin
            failures++; $display("FAIL rst_first_op got v=%b d=%h want v=1 d=10000", v1, d1);
        end
    endtask

    initial begin
        test_reset();
        test_add_directed();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        test_pulse();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_unit.md
ADDER_UNIT -- requirements
Module: adder_unit

Interface
REQ-001 Parameter DATA_WIDTH_1, default 16, bit width of operand 1 (range 1..64).
REQ-002 Parameter DATA_WIDTH_2, default 16, bit width of operand 2 (range 1..64).
REQ-003 Parameter PIPE_STAGES, default 1, output register stages (range 1..4).
REQ-004 Derived constant OUT_W SHALL equal max(DATA_WIDTH_1, DATA_WIDTH_2)+1.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 valid_i  input  1  operands valid this cycle.
REQ-008 data1_i  input  DATA_WIDTH_1  operand A, unsigned.
REQ-009 data2_i  input  DATA_WIDTH_2  operand B, unsigned.
REQ-010 sub_i  input  1  1 = A-B, 0 = A+B (present only with ADDER_SUB_EN).
REQ-011 valid_o  output  1  data_o holds a result.
REQ-012 data_o  output  OUT_W  result.

Function
REQ-013 Both operands SHALL be zero-extended to OUT_W before the operation.
REQ-014 Add: data_o SHALL equal A+B exactly; no overflow possible at OUT_W bits.
REQ-015 Subtract: data_o SHALL equal (A-B) mod 2^OUT_W; MSB set indicates A<B (two's-complement negative).
REQ-016 Latency SHALL be exactly PIPE_STAGES cycles from a valid_i=1 edge to matching valid_o=1/data_o.
REQ-017 Throughput SHALL be one operation per cycle; no back-pressure, no stall input.
REQ-018 valid_o SHALL be valid_i delayed by PIPE_STAGES cycles, in order, no drops.
REQ-019 When valid_i=0, pipeline data registers SHALL hold their previous value; data_o is don't-care to consumers but SHALL be stable.
REQ-020 Operands are sampled only on edges where valid_i=1; sub_i is sampled with them.

Reset
REQ-021 rst=1 SHALL immediately clear valid_o and all internal valid bits, and set data_o and all data registers to 0.
REQ-022 Operations in flight when rst asserts SHALL be discarded; none emerges after reset release.
REQ-023 The first operation accepted is the first valid_i=1 rising edge with rst=0.

Configuration
REQ-024 Macro ADDER_SUB_EN defined: sub_i port exists and REQ-015 applies.
REQ-025 ADDER_SUB_EN undefined: sub_i port absent; unit always adds; no subtract logic synthesized.

Structure
REQ-026 Package adder_pkg SHALL hold default widths (16), PIPE_STAGES default, and a max-width function used to derive OUT_W.
REQ-027 One sub-module adder_pipe_reg (one valid+data register stage with async reset) SHALL be instantiated PIPE_STAGES times via generate.

Verification
REQ-028 Defaults, add: A=0x52F2, B=0x3671 -> data_o=0x08963 one cycle later, valid_o=1.
REQ-029 Back-to-back adds: (0x52F2,0x2234),(0x8929,0x2234),(0x8712,0x4142) on consecutive cycles -> 0x07526, 0x0AB5D, 0x0C854 on consecutive cycles.
REQ-030 Boundary: A=0xFFFF, B=0xFFFF add -> 0x1FFFE; A=0, B=0 -> 0x00000.
REQ-031 ADDER_SUB_EN: A=0x52F2, B=0x3671 sub -> 0x01C81; A=0x3671, B=0x52F2 sub -> 0x1E37F.
REQ-032 PIPE_STAGES=3, valid_i pulse pattern 1,0,1 -> valid_o pattern 1,0,1 starting 3 cycles later with matching results.
REQ-033 Assert rst mid-stream with 2 ops in flight (PIPE_STAGES=3) -> valid_o=0, data_o=0 immediately; no stale result after release.
